// File: rtl/camera_pixel_capture.sv
// camera_pixel_capture: samples a slow camera byte bus using the synchronized pclk as a strobe,
// packs byte pairs into sof/eol-tagged 16-bit pixels and queues them for a valid/ready consumer.
module camera_pixel_capture #(
    parameter int FIFO_DEPTH = 4,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    output logic [15:0]      pix_data,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [COL_W-1:0] col_count,
    output logic [ROW_W-1:0] row_count,
    output logic             overflow,
    output logic             frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;
    state_t state, state_nx;

    logic [10:0] sync1, sync2;
    logic        pclk_d, pe, vs, hr;
    logic [7:0]  d;
    logic        vs_last, hr_last, phase, pend_v, sof_arm, push_v;
    logic [7:0]  hi_byte;
    logic [15:0] pending;
    logic [17:0] push_e;
    logic        frame_start, frame_end, byte_in, line_end;

    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0]   count;
    logic          full, pop, push_ok;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            pclk_d <= 1'b0;
        end else begin
            sync1  <= {cam_pclk, cam_vsync, cam_href, cam_data};
            sync2  <= sync1;
            pclk_d <= sync2[10];
        end

    assign pe = sync2[10] & ~pclk_d;
    assign vs = sync2[9];
    assign hr = sync2[8];
    assign d  = sync2[7:0];

    assign frame_start = pe && state == WAIT_FRAME && vs_last && !vs;
    assign frame_end   = pe && state == ACTIVE && vs;
    assign byte_in     = pe && state == ACTIVE && !vs && hr;
    assign line_end    = pe && state == ACTIVE && !vs && !hr && hr_last;

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE && enable) state_nx = WAIT_FRAME;
        if (frame_start)             state_nx = ACTIVE;
        if (frame_end)               state_nx = enable ? WAIT_FRAME : IDLE;
    end

    // Pushes are staged one cycle so the FIFO write is a plain registered event.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            vs_last    <= 1'b0;
            hr_last    <= 1'b0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            sof_arm    <= 1'b0;
            push_v     <= 1'b0;
            push_e     <= '0;
            col_count  <= '0;
            row_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            push_v     <= 1'b0;
            frame_done <= frame_end;
            if (pe) begin
                vs_last <= vs;
                hr_last <= hr;
            end
            if (frame_start) begin
                col_count <= '0;
                row_count <= '0;
                sof_arm   <= 1'b1;
                phase     <= 1'b0;
                pend_v    <= 1'b0;
            end
            if (byte_in) begin
                phase <= ~phase;
                if (!phase) hi_byte <= d;
                else begin
                    pending   <= {hi_byte, d};
                    pend_v    <= 1'b1;
                    col_count <= (col_count == '1) ? col_count : col_count + 1'b1;
                    if (pend_v) begin
                        push_v  <= 1'b1;
                        push_e  <= {sof_arm, 1'b0, pending};
                        sof_arm <= 1'b0;
                    end
                end
            end
            if ((line_end || frame_end) && pend_v) begin
                push_v  <= 1'b1;
                push_e  <= {sof_arm, 1'b1, pending};
                sof_arm <= 1'b0;
                pend_v  <= 1'b0;
            end
            if (line_end) begin
                row_count <= (row_count == '1) ? row_count : row_count + 1'b1;
                col_count <= '0;
                phase     <= 1'b0;
            end
            if (frame_end) phase <= 1'b0;
        end

    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign pix_valid = count != '0;
    assign pop     = pix_valid & pix_ready;
    assign push_ok = push_v & (~full | pop);

    always_ff @(posedge clock)
        if (push_ok) mem[wr] <= push_e;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wr       <= '0;
            rd       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr <= wr + 1'b1;
            if (pop)     rd <= rd + 1'b1;
            count <= count + {AW'(0), push_ok} - {AW'(0), pop};
            if (push_v && full && !pop) overflow <= 1'b1;
            if (frame_start)            overflow <= 1'b0;
        end

    assign {pix_sof, pix_eol, pix_data} = pix_valid ? mem[rd] : 18'h0;
endmodule

// File: tb/tb_camera_pixel_capture.sv
// tb_camera_pixel_capture: directed camera frames with hand-computed pixel expectations.
module tb_camera_pixel_capture;
    logic        clock = 1'b0, reset = 1'b0, enable = 1'b0;
    logic        cam_pclk = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0, pix_ready = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic [15:0] pix_data;
    logic        pix_sof, pix_eol, pix_valid, overflow, frame_done;
    logic [9:0]  col_count;
    logic [8:0]  row_count;

    int n_pass = 0, n_total = 0, fd_cnt = 0, fd0;
    logic [17:0] got [$];
    logic [17:0] t1 [4];

    typedef struct {
        int          nb;
        logic [7:0]  base;
        int          col;
        int          row;
        int          npix;
        logic [17:0] first;
        logic [17:0] last;
    } vec_t;
    vec_t vecs [4];

    camera_pixel_capture dut (
        .clock(clock), .reset(reset), .enable(enable),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .col_count(col_count), .row_count(row_count),
        .overflow(overflow), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        #1;
        if (pix_valid && pix_ready) got.push_back({pix_sof, pix_eol, pix_data});
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [17:0] at(input int k);
        return (k >= 0 && k < got.size()) ? got[k] : 18'h0;
    endfunction

    task automatic pc(input logic vs, input logic hr, input logic [7:0] dd);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = dd;
        repeat (12) @(negedge clock);
        cam_pclk = 1'b1;
        repeat (12) @(negedge clock);
        cam_pclk = 1'b0;
    endtask

    task automatic send_bytes(input int nb, input logic [7:0] base);
        for (int i = 0; i < nb; i++) pc(1'b0, 1'b1, base + 8'(i));
    endtask

    task automatic frame_start();
        pc(1'b1, 1'b0, 8'h00);
        pc(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        t1[0] = {1'b1, 1'b0, 16'h0102};
        t1[1] = {1'b0, 1'b0, 16'h0304};
        t1[2] = {1'b0, 1'b0, 16'h0506};
        t1[3] = {1'b0, 1'b1, 16'h0708};
        vecs[0] = '{4, 8'h10, 2, 1, 2, {1'b1, 1'b0, 16'h1011}, {1'b0, 1'b1, 16'h1213}};
        vecs[1] = '{4, 8'h20, 2, 2, 2, {1'b0, 1'b0, 16'h2021}, {1'b0, 1'b1, 16'h2223}};
        vecs[2] = '{5, 8'hA0, 2, 3, 2, {1'b0, 1'b0, 16'hA0A1}, {1'b0, 1'b1, 16'hA2A3}};
        vecs[3] = '{4, 8'h30, 2, 4, 2, {1'b0, 1'b0, 16'h3031}, {1'b0, 1'b1, 16'h3233}};

        repeat (3) @(negedge clock);
        chk("rst pix_data", pix_data, 0);
        chk("rst pix_sof", pix_sof, 0);
        chk("rst pix_eol", pix_eol, 0);
        chk("rst pix_valid", pix_valid, 0);
        chk("rst col_count", col_count, 0);
        chk("rst row_count", row_count, 0);
        chk("rst overflow", overflow, 0);
        chk("rst frame_done", frame_done, 0);
        reset = 1'b1;
        enable = 1'b1;
        pix_ready = 1'b1;

        frame_start();
        got.delete();
        send_bytes(8, 8'h01);
        chk("line1 col", col_count, 4);
        pc(1'b0, 1'b0, 8'h00);
        chk("line1 col clr", col_count, 0);
        chk("line1 row", row_count, 1);
        chk("line1 npix", got.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("line1 pix%0d", k), at(k), t1[k]);
        got.delete();
        fd0 = fd_cnt;
        pc(1'b1, 1'b0, 8'h00);
        chk("frameA done", fd_cnt - fd0, 1);
        chk("frameA no flush", got.size(), 0);

        frame_start();
        for (int v = 0; v < 4; v++) begin
            got.delete();
            send_bytes(vecs[v].nb, vecs[v].base);
            chk($sformatf("v%0d col", v), col_count, vecs[v].col);
            pc(1'b0, 1'b0, 8'h00);
            chk($sformatf("v%0d row", v), row_count, vecs[v].row);
            chk($sformatf("v%0d npix", v), got.size(), vecs[v].npix);
            chk($sformatf("v%0d first", v), at(0), vecs[v].first);
            chk($sformatf("v%0d last", v), at(vecs[v].npix - 1), vecs[v].last);
        end
        got.delete();
        fd0 = fd_cnt;
        pc(1'b1, 1'b0, 8'h00);
        chk("frameB done", fd_cnt - fd0, 1);
        chk("frameB no flush", got.size(), 0);

        frame_start();
        got.delete();
        fd0 = fd_cnt;
        send_bytes(4, 8'h40);
        pc(1'b1, 1'b0, 8'h00);
        chk("flush npix", got.size(), 2);
        chk("flush p0", at(0), {1'b1, 1'b0, 16'h4041});
        chk("flush p1", at(1), {1'b0, 1'b1, 16'h4243});
        chk("flush done", fd_cnt - fd0, 1);

        frame_start();
        chk("bp ovf pre", overflow, 0);
        pix_ready = 1'b0;
        got.delete();
        send_bytes(12, 8'h50);
        pc(1'b0, 1'b0, 8'h00);
        chk("bp overflow", overflow, 1);
        chk("bp valid", pix_valid, 1);
        chk("bp head", {pix_sof, pix_eol, pix_data}, {1'b1, 1'b0, 16'h5051});
        @(negedge clock);
        pix_ready = 1'b1;
        repeat (10) @(negedge clock);
        chk("bp drained", got.size(), 4);
        chk("bp p0", at(0), {1'b1, 1'b0, 16'h5051});
        chk("bp p3", at(3), {1'b0, 1'b0, 16'h5657});
        chk("bp empty", pix_valid, 0);
        chk("bp ovf sticky", overflow, 1);
        pc(1'b1, 1'b0, 8'h00);
        chk("bp ovf after end", overflow, 1);
        frame_start();
        chk("bp ovf cleared", overflow, 0);

        got.delete();
        send_bytes(2, 8'h80);
        enable = 1'b0;
        send_bytes(2, 8'h82);
        pc(1'b0, 1'b0, 8'h00);
        chk("en npix", got.size(), 2);
        chk("en p0", at(0), {1'b1, 1'b0, 16'h8081});
        chk("en p1", at(1), {1'b0, 1'b1, 16'h8283});
        fd0 = fd_cnt;
        pc(1'b1, 1'b0, 8'h00);
        chk("en done", fd_cnt - fd0, 1);
        frame_start();
        got.delete();
        send_bytes(4, 8'h90);
        chk("idle col", col_count, 0);
        pc(1'b0, 1'b0, 8'h00);
        chk("idle npix", got.size(), 0);
        chk("idle row", row_count, 1);
        enable = 1'b1;
        frame_start();
        got.delete();
        send_bytes(4, 8'hB0);
        pc(1'b0, 1'b0, 8'h00);
        chk("reen npix", got.size(), 2);
        chk("reen p0", at(0), {1'b1, 1'b0, 16'hB0B1});

        pix_ready = 1'b0;
        got.delete();
        send_bytes(6, 8'h60);
        chk("pre-rst valid", pix_valid, 1);
        chk("pre-rst head", pix_data, 16'h6061);
        chk("pre-rst col", col_count, 3);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid-rst valid", pix_valid, 0);
        chk("mid-rst data", pix_data, 0);
        chk("mid-rst sof", pix_sof, 0);
        chk("mid-rst eol", pix_eol, 0);
        chk("mid-rst col", col_count, 0);
        chk("mid-rst row", row_count, 0);
        chk("mid-rst ovf", overflow, 0);
        chk("mid-rst fd", frame_done, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        pix_ready = 1'b1;
        send_bytes(4, 8'h68);
        pc(1'b0, 1'b0, 8'h00);
        chk("post-rst stale", got.size(), 0);
        chk("post-rst col", col_count, 0);
        frame_start();
        got.delete();
        send_bytes(4, 8'h70);
        pc(1'b0, 1'b0, 8'h00);
        chk("resume npix", got.size(), 2);
        chk("resume p0", at(0), {1'b1, 1'b0, 16'h7071});
        chk("resume p1", at(1), {1'b0, 1'b1, 16'h7273});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/camera_pixel_capture.md
# camera_pixel_capture

Receive-side companion to the camera clock divider. It samples the camera's parallel pixel bus in the system `clock` domain, using the divided `cam_pclk` returned by the sensor as a strobe. It assembles byte pairs into 16-bit pixels and tags start-of-frame and end-of-line. Pixels are buffered in a small FIFO and handed downstream over a valid/ready interface.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; power of 2, ≥2.
- `COL_W`, default 10: width of `col_count`.
- `ROW_W`, default 9: width of `row_count`.

Ports:
- `clock`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable; sampled at frame boundaries.
- `cam_pclk`  in  1  camera pixel clock; asynchronous, slow.
- `cam_vsync`  in  1  high = vertical blanking.
- `cam_href`  in  1  high = active line bytes.
- `cam_data`  in  8  camera byte bus.
- `pix_data`  out  16  FIFO head pixel, `{first byte, second byte}`.
- `pix_sof`  out  1  head pixel is first of frame.
- `pix_eol`  out  1  head pixel is last of line.
- `pix_valid`  out  1  FIFO non-empty.
- `pix_ready`  in  1  downstream accepts head.
- `col_count`  out  COL_W  pixels formed in current line.
- `row_count`  out  ROW_W  lines completed in current frame.
- `overflow`  out  1  sticky: a pixel was dropped on FIFO full.
- `frame_done`  out  1  one-cycle pulse at end of frame.

## Operation
- **Synchronizer.** `cam_pclk`, `cam_vsync`, `cam_href` and `cam_data` all pass through identical 2-flop synchronizers. Edge detect on synced pclk: `pe = s & ~s_d`. All camera-side logic below acts only on cycles with `pe`, using the synced vsync/href/data.
- **State machine:**
  - IDLE: if `enable`, go to WAIT_FRAME.
  - WAIT_FRAME: on `pe` with vsync sampled low after having been high (falling vsync), go to ACTIVE. Clear `row_count`, `col_count` and `overflow`; arm the SOF flag.
  - ACTIVE: on `pe` with vsync high, pulse `frame_done` and flush pending (see below). Next state is WAIT_FRAME if `enable`, else IDLE.
  - `enable` deasserting mid-frame takes effect only at frame end.
- **Byte assembly.** In ACTIVE, on `pe` with href high:
  - phase 0: latch high byte.
  - phase 1: form pixel, `col_count` += 1 (saturate at all-ones).
  - Phase toggles on each such `pe`.
- **Pending register.** Each formed pixel is held in `pending`. The previous pending pixel, if any, is pushed with eol=0 when the next pixel forms.
- **Line end.** On `pe` where href falls (sampled high then low):
  - pending is pushed with eol=1.
  - `row_count` += 1 (saturate).
  - `col_count` is cleared, phase is cleared, and an orphan odd byte is discarded.
  - A line end with no pending pixel pushes nothing but still counts the row.
- **SOF.** The first pixel pushed after ACTIVE entry carries sof=1, and the flag then disarms.
- **Frame flush.** Vsync rising while pending is valid pushes pending with eol=1.
- **FIFO.** Entries are `{sof, eol, data}`, show-ahead. Pop happens on `pix_valid & pix_ready`.
  - Push when full with no pop in the same cycle: entry dropped, `overflow` set.
  - Push and pop in the same cycle when full: accepted, count unchanged.
- **Reset.** Mid-operation reset returns to IDLE and empties FIFO and pending.

## Timing
- Reset values: `pix_data` 0, `pix_sof` 0, `pix_eol` 0, `pix_valid` 0, `col_count` 0, `row_count` 0, `overflow` 0, `frame_done` 0, state IDLE, phase 0.
- `pe` asserts 3 `clock` cycles after a `cam_pclk` rising edge.
- A pixel's FIFO push occurs on the `pe` of the next pixel's second byte, or of the href/vsync fall, plus one cycle for the register write. `pix_valid` rises the cycle after the push.
- `cam_pclk` high and low times must each be ≥3 `clock` cycles. At 100 MHz with ~4.17 MHz pclk (12/12 cycles) there is ample margin.
- Camera inputs must be stable ≥2 `clock` cycles before a pclk rising edge.
- `frame_done` is high for exactly 1 cycle, in the cycle after the vsync-rise `pe`.

## Test plan
- **Single line.**
  - Stimulus: `enable`=1, vsync 1→0, one line of 8 bytes 0x01..0x08, `pix_ready`=1.
  - Required: pixels 0x0102, 0x0304, 0x0506, 0x0708; sof only on 0x0102, eol only on 0x0708; `col_count`=4 then 0; `row_count`=1.
- **Two lines then frame end.**
  - Stimulus: two 4-byte lines, then vsync rises.
  - Required: 4 pixels, eol on the 2nd and 4th; `row_count`=2; one `frame_done` pulse; state returns to WAIT_FRAME.
- **Backpressure.**
  - Stimulus: `pix_ready`=0, line of 12 bytes.
  - Required: FIFO fills at 4; 5th and 6th pixels dropped; `overflow`=1.
  - Then `pix_ready`=1: exactly 4 pixels drain. `overflow` stays 1 until the next frame start.
- **Odd line.**
  - Stimulus: 5-byte line 0xA0..0xA4.
  - Required: pixels 0xA0A1, 0xA2A3 with eol on the second; 0xA4 discarded; next line starts at phase 0.
- **Enable drop mid-frame.**
  - Stimulus: `enable`→0 during a line.
  - Required: the frame completes normally with `frame_done`, then IDLE; subsequent vsync falls are ignored.
- **Reset mid-line.**
  - Stimulus: assert `reset` with 2 pixels queued.
  - Required: all outputs return to their reset values immediately; after release no stale pixels appear, and capture resumes only after a new vsync fall.
